// File: rtl/sprite_move_ctrl.sv
// Arrow-key sprite mover: decodes PS/2 make/break codes into held-key bits and
// steps a clamped overlay position once per REPEAT_FRAMES frames, only at frame start.
module sprite_move_ctrl #(
    parameter int ROWS          = 480,
    parameter int COLS          = 640,
    parameter int H             = 20,
    parameter int W             = 20,
    parameter int STEP          = 1,
    parameter int INIT_ROW      = 100,
    parameter int INIT_COL      = 100,
    parameter int REPEAT_FRAMES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    input  logic       frame_start,
    output logic [9:0] pos_row,
    output logic [9:0] pos_col,
    output logic       moving,
    output logic       move_pulse
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_t;

    localparam int CW = $clog2(REPEAT_FRAMES) + 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(REPEAT_FRAMES - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic signed [10:0] STEP_S   = 11'(STEP);
    localparam logic signed [10:0] ROW_MAX  = 11'(ROWS - H);
    localparam logic signed [10:0] COL_MAX  = 11'(COLS - W);

    // held bit order: [0]=L, [1]=R, [2]=U, [3]=D
    dec_state_t        state_r, state_s;
    logic [3:0]        held_r, held_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic              move_s;
    logic [9:0]        row_next_s, col_next_s;
    logic signed [10:0] row_try_s, col_try_s;

    // Scan-code decoder: prefix tracking and held-bit resolution
    always_comb begin
        state_s = state_r;
        held_s  = held_r;
        if (scan_valid) begin
            if (scan_code == 8'hE0) begin
                state_s = EXT;
            end else if (scan_code == 8'hF0) begin
                case (state_r)
                    IDLE:    state_s = BRK;
                    EXT:     state_s = EXT_BRK;
                    BRK:     state_s = BRK;
                    EXT_BRK: state_s = EXT_BRK;
                    default: state_s = IDLE;
                endcase
            end else begin
                state_s = IDLE;
                if ((state_r == EXT) || (state_r == EXT_BRK)) begin
                    case (scan_code)
                        8'h6B:   held_s[0] = (state_r == EXT);
                        8'h74:   held_s[1] = (state_r == EXT);
                        8'h75:   held_s[2] = (state_r == EXT);
                        8'h72:   held_s[3] = (state_r == EXT);
                        default: held_s    = held_r;
                    endcase
                end else begin
                    held_s = held_r;
                end
            end
        end else begin
            state_s = state_r;
        end
    end

    // Move event, prioritised single-axis step with saturation, and frame counter
    always_comb begin
        move_s     = frame_start && (held_r != 4'b0000) && (cnt_r == {CW{1'b0}});
        row_next_s = pos_row;
        col_next_s = pos_col;
        row_try_s  = $signed({1'b0, pos_row});
        col_try_s  = $signed({1'b0, pos_col});
        if (!move_s) begin
            row_next_s = pos_row;
        end else if (held_r[0]) begin
            col_try_s  = $signed({1'b0, pos_col}) - STEP_S;
            col_next_s = (col_try_s < 11'sd0) ? 10'd0 : col_try_s[9:0];
        end else if (held_r[1]) begin
            col_try_s  = $signed({1'b0, pos_col}) + STEP_S;
            col_next_s = (col_try_s > COL_MAX) ? COL_MAX[9:0] : col_try_s[9:0];
        end else if (held_r[2]) begin
            row_try_s  = $signed({1'b0, pos_row}) - STEP_S;
            row_next_s = (row_try_s < 11'sd0) ? 10'd0 : row_try_s[9:0];
        end else begin
            row_try_s  = $signed({1'b0, pos_row}) + STEP_S;
            row_next_s = (row_try_s > ROW_MAX) ? ROW_MAX[9:0] : row_try_s[9:0];
        end

        if (held_r == 4'b0000) begin
            cnt_s = {CW{1'b0}};
        end else if (frame_start) begin
            cnt_s = (cnt_r == CNT_LAST) ? {CW{1'b0}} : (cnt_r + CNT_ONE);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State, position and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            held_r     <= 4'b0000;
            cnt_r      <= {CW{1'b0}};
            pos_row    <= 10'(INIT_ROW);
            pos_col    <= 10'(INIT_COL);
            moving     <= 1'b0;
            move_pulse <= 1'b0;
        end else begin
            state_r    <= state_s;
            held_r     <= held_s;
            cnt_r      <= cnt_s;
            pos_row    <= row_next_s;
            pos_col    <= col_next_s;
            moving     <= |held_s;
            move_pulse <= (row_next_s != pos_row) || (col_next_s != pos_col);
        end
    end

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// Scoreboard bench for sprite_move_ctrl: expectations are queued as each frame is
// driven and popped when the registered outputs appear one clock later.
module tb_sprite_move_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scan_valid = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       frame_start = 1'b0;
    logic [9:0] pos_row, pos_col, pos_row3, pos_col3;
    logic       moving, move_pulse, moving3, move_pulse3;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [9:0] row;
        logic [9:0] col;
        logic       pulse;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    sprite_move_ctrl dut (
        .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_code(scan_code),
        .frame_start(frame_start), .pos_row(pos_row), .pos_col(pos_col),
        .moving(moving), .move_pulse(move_pulse)
    );

    sprite_move_ctrl #(.REPEAT_FRAMES(3)) dut3 (
        .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_code(scan_code),
        .frame_start(frame_start), .pos_row(pos_row3), .pos_col(pos_col3),
        .moving(moving3), .move_pulse(move_pulse3)
    );

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); scan_valid = 1'b1; scan_code = b;
        @(negedge clk); scan_valid = 1'b0; scan_code = 8'h00;
    endtask

    task automatic pulse_frame();
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
    endtask

    task automatic push_exp(input int row, input int col, input logic pulse);
        exp_t x;
        x.row = 10'(row); x.col = 10'(col); x.pulse = pulse;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (pos_row !== 10'd100 || pos_col !== 10'd100) begin
            errors++; $display("FAIL reset_pos: got %0d/%0d expected 100/100", pos_row, pos_col);
        end
        checks++;
        if (moving !== 1'b0 || move_pulse !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got moving=%0b pulse=%0b expected 0/0", moving, move_pulse);
        end
        checks++;
        if (pos_row3 !== 10'd100 || pos_col3 !== 10'd100 || moving3 !== 1'b0) begin
            errors++; $display("FAIL reset_dut3: got %0d/%0d m=%0b expected 100/100 m=0", pos_row3, pos_col3, moving3);
        end
    endtask

    task automatic test_right_make();
        send_byte(8'hE0); send_byte(8'h74);
        checks++;
        if (moving !== 1'b1) begin
            errors++; $display("FAIL right_moving: got %0b expected 1", moving);
        end
        for (int i = 1; i <= 3; i++) begin
            push_exp(100, 100 + i, 1'b1);
            pulse_frame();
            e = sb.pop_front();
            checks++;
            if (pos_row !== e.row || pos_col !== e.col || move_pulse !== e.pulse) begin
                errors++; $display("FAIL right_frame%0d: got %0d/%0d p=%0b expected %0d/%0d p=%0b",
                                   i, pos_row, pos_col, move_pulse, e.row, e.col, e.pulse);
            end
        end
        @(negedge clk);
        checks++;
        if (move_pulse !== 1'b0) begin
            errors++; $display("FAIL right_pulse_width: got %0b expected 0", move_pulse);
        end
    endtask

    task automatic test_break();
        send_byte(8'hF0); send_byte(8'h74);
        checks++;
        if (moving !== 1'b1) begin
            errors++; $display("FAIL plain_break_kept: got moving=%0b expected 1", moving);
        end
        push_exp(100, 104, 1'b1);
        pulse_frame();
        e = sb.pop_front();
        checks++;
        if (pos_col !== e.col || move_pulse !== e.pulse) begin
            errors++; $display("FAIL plain_break_move: got %0d p=%0b expected %0d p=%0b", pos_col, move_pulse, e.col, e.pulse);
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        checks++;
        if (moving !== 1'b0) begin
            errors++; $display("FAIL ext_break_moving: got %0b expected 0", moving);
        end
        for (int i = 0; i < 2; i++) begin
            push_exp(100, 104, 1'b0);
            pulse_frame();
            e = sb.pop_front();
            checks++;
            if (pos_row !== e.row || pos_col !== e.col || move_pulse !== e.pulse) begin
                errors++; $display("FAIL frozen_frame%0d: got %0d/%0d p=%0b expected %0d/%0d p=%0b",
                                   i, pos_row, pos_col, move_pulse, e.row, e.col, e.pulse);
            end
        end
    endtask

    task automatic test_priority();
        do_reset();
        send_byte(8'hE0); send_byte(8'h6B);
        send_byte(8'hE0); send_byte(8'h72);
        for (int i = 1; i <= 2; i++) begin
            push_exp(100, 100 - i, 1'b1);
            pulse_frame();
            e = sb.pop_front();
            checks++;
            if (pos_row !== e.row || pos_col !== e.col || move_pulse !== e.pulse) begin
                errors++; $display("FAIL prio_frame%0d: got %0d/%0d p=%0b expected %0d/%0d p=%0b",
                                   i, pos_row, pos_col, move_pulse, e.row, e.col, e.pulse);
            end
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        push_exp(101, 98, 1'b1);
        pulse_frame();
        e = sb.pop_front();
        checks++;
        if (pos_row !== e.row || pos_col !== e.col || move_pulse !== e.pulse) begin
            errors++; $display("FAIL prio_down: got %0d/%0d p=%0b expected %0d/%0d p=%0b",
                               pos_row, pos_col, move_pulse, e.row, e.col, e.pulse);
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
    endtask

    task automatic test_clamp();
        do_reset();
        send_byte(8'hE0); send_byte(8'h6B);
        for (int i = 1; i <= 103; i++) begin
            push_exp(100, (i <= 100) ? 100 - i : 0, (i <= 100));
            pulse_frame();
            e = sb.pop_front();
            checks++;
            if (pos_col !== e.col || move_pulse !== e.pulse) begin
                errors++; $display("FAIL clamp_left%0d: got %0d p=%0b expected %0d p=%0b", i, pos_col, move_pulse, e.col, e.pulse);
            end
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        send_byte(8'hE0); send_byte(8'h74);
        for (int i = 1; i <= 622; i++) begin
            push_exp(100, (i <= 620) ? i : 620, (i <= 620));
            pulse_frame();
            e = sb.pop_front();
            if (i >= 618) begin
                checks++;
                if (pos_col !== e.col || move_pulse !== e.pulse) begin
                    errors++; $display("FAIL clamp_right%0d: got %0d p=%0b expected %0d p=%0b", i, pos_col, move_pulse, e.col, e.pulse);
                end
            end
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    endtask

    task automatic test_repeat();
        int moves;
        do_reset();
        moves = 0;
        send_byte(8'hE0); send_byte(8'h72);
        for (int k = 1; k <= 7; k++) begin
            if (k == 1 || k == 4 || k == 7) moves++;
            push_exp(100 + moves, 100, (k == 1 || k == 4 || k == 7));
            pulse_frame();
            e = sb.pop_front();
            checks++;
            if (pos_row3 !== e.row || pos_col3 !== e.col || move_pulse3 !== e.pulse) begin
                errors++; $display("FAIL repeat_frame%0d: got %0d/%0d p=%0b expected %0d/%0d p=%0b",
                                   k, pos_row3, pos_col3, move_pulse3, e.row, e.col, e.pulse);
            end
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
        send_byte(8'hE0); send_byte(8'h72);
        push_exp(104, 100, 1'b1);
        pulse_frame();
        e = sb.pop_front();
        checks++;
        if (pos_row3 !== e.row || move_pulse3 !== e.pulse) begin
            errors++; $display("FAIL repeat_repress: got %0d p=%0b expected %0d p=%0b", pos_row3, move_pulse3, e.row, e.pulse);
        end
    endtask

    task automatic test_reset_prefix();
        do_reset();
        send_byte(8'hE0);
        do_reset();
        send_byte(8'h6B);
        checks++;
        if (moving !== 1'b0) begin
            errors++; $display("FAIL prefix_discard_moving: got %0b expected 0", moving);
        end
        push_exp(100, 100, 1'b0);
        pulse_frame();
        e = sb.pop_front();
        checks++;
        if (pos_row !== e.row || pos_col !== e.col || move_pulse !== e.pulse) begin
            errors++; $display("FAIL prefix_discard_pos: got %0d/%0d p=%0b expected %0d/%0d p=%0b",
                               pos_row, pos_col, move_pulse, e.row, e.col, e.pulse);
        end
        send_byte(8'hE0);
        push_exp(100, 100, 1'b0);
        @(negedge clk); scan_valid = 1'b1; scan_code = 8'h6B; frame_start = 1'b1;
        @(negedge clk); scan_valid = 1'b0; scan_code = 8'h00; frame_start = 1'b0;
        e = sb.pop_front();
        checks++;
        if (pos_col !== e.col || move_pulse !== e.pulse || moving !== 1'b1) begin
            errors++; $display("FAIL simul_frame: got %0d p=%0b m=%0b expected %0d p=%0b m=1",
                               pos_col, move_pulse, moving, e.col, e.pulse);
        end
        push_exp(100, 99, 1'b1);
        pulse_frame();
        e = sb.pop_front();
        checks++;
        if (pos_col !== e.col || move_pulse !== e.pulse) begin
            errors++; $display("FAIL simul_next: got %0d p=%0b expected %0d p=%0b", pos_col, move_pulse, e.col, e.pulse);
        end
    endtask

    initial begin
        test_reset();
        test_right_make();
        test_break();
        test_priority();
        test_clamp();
        test_repeat();
        test_reset_prefix();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
